// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: period codes (also the transmit mux select),
// control-code symbols and per-channel video guard-band symbols.
package tmds_pkg;

  typedef enum logic [1:0] {
    P_BLANK = 2'b00,
    P_GUARD = 2'b01,
    P_VIDEO = 2'b10
  } period_t;

  typedef enum logic [1:0] {
    S_BLANK = 2'b00,
    S_GUARD = 2'b01,
    S_VIDEO = 2'b10
  } dec_state_t;

  localparam logic [9:0] CTL_00 = 10'b1101010100;
  localparam logic [9:0] CTL_01 = 10'b0010101011;
  localparam logic [9:0] CTL_10 = 10'b0101010100;
  localparam logic [9:0] CTL_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_CH0 = 10'b1011001100;
  localparam logic [9:0] GUARD_CH1 = 10'b0100110011;

endpackage

// File: rtl/tmds_sym_classify.sv
// Combinational classifier: flags control symbols (with their 2-bit code)
// and the channel's video leading guard-band symbol.
module tmds_sym_classify
  import tmds_pkg::*;
#(
  parameter logic [9:0] GUARD_SYM = GUARD_CH0
) (
  input  logic [9:0] sym,
  output logic       is_ctl,
  output logic [1:0] ctl_code,
  output logic       is_guard
);

  always_comb begin
    is_ctl   = 1'b1;
    ctl_code = 2'b00;
    case (sym)
      CTL_00:  ctl_code = 2'b00;
      CTL_01:  ctl_code = 2'b01;
      CTL_10:  ctl_code = 2'b10;
      CTL_11:  ctl_code = 2'b11;
      default: is_ctl = 1'b0;
    endcase
  end

  assign is_guard = (sym == GUARD_SYM);

endmodule

// File: rtl/tmds_period_decoder.sv
// Sink-side TMDS period decoder for one channel: preamble -> guard -> video tracking.
// Optional pixel counter / line_len enabled by defining PIXEL_COUNT_EN.
module tmds_period_decoder
  import tmds_pkg::*;
#(
  parameter logic [9:0] GUARD_SYM    = GUARD_CH0,
  parameter int         PREAMBLE_LEN = 8,
  parameter int         CNT_W        = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [9:0]       in_sym,
  output logic             out_valid,
  output logic [9:0]       out_sym,
  output logic [1:0]       period,
  output logic [1:0]       ctl,
  output logic             video_start,
  output logic             video_end,
  output logic             err,
  output logic [CNT_W-1:0] line_len
);

  localparam int RUN_W = $clog2(PREAMBLE_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PREAMBLE_LEN);

  logic             is_ctl;
  logic [1:0]       ctl_code;
  logic             is_guard;
  dec_state_t       state;
  logic [RUN_W-1:0] run_cnt;
  logic             first_data;

  tmds_sym_classify #(.GUARD_SYM(GUARD_SYM)) u_classify (
    .sym      (in_sym),
    .is_ctl   (is_ctl),
    .ctl_code (ctl_code),
    .is_guard (is_guard)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BLANK;
      run_cnt     <= '0;
      first_data  <= 1'b0;
      out_valid   <= 1'b0;
      out_sym     <= 10'd0;
      period      <= P_BLANK;
      ctl         <= 2'b00;
      video_start <= 1'b0;
      video_end   <= 1'b0;
      err         <= 1'b0;
    end else begin
      out_valid   <= in_valid;
      video_start <= 1'b0;
      video_end   <= 1'b0;
      err         <= 1'b0;
      if (in_valid) begin
        out_sym <= in_sym;
        case (state)
          S_BLANK: begin
            if (is_ctl) begin
              period <= P_BLANK;
              ctl    <= ctl_code;
              // a run continues only while the code repeats
              if (ctl_code == ctl) begin
                run_cnt <= (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
              end else begin
                run_cnt <= RUN_W'(1);
              end
            end else if (is_guard && (run_cnt >= RUN_MAX)) begin
              state  <= S_GUARD;
              period <= P_GUARD;
            end else begin
              err     <= 1'b1;
              run_cnt <= '0;
              period  <= P_BLANK;
            end
          end
          S_GUARD: begin
            if (is_guard) begin
              state      <= S_VIDEO;
              period     <= P_GUARD;
              first_data <= 1'b1;
            end else if (is_ctl) begin
              err     <= 1'b1;
              state   <= S_BLANK;
              run_cnt <= RUN_W'(1);
              ctl     <= ctl_code;
              period  <= P_BLANK;
            end else begin
              err     <= 1'b1;
              state   <= S_BLANK;
              run_cnt <= '0;
              period  <= P_BLANK;
            end
          end
          S_VIDEO: begin
            if (is_ctl) begin
              state      <= S_BLANK;
              run_cnt    <= RUN_W'(1);
              ctl        <= ctl_code;
              video_end  <= 1'b1;
              first_data <= 1'b0;
              period     <= P_BLANK;
            end else begin
              // guard symbols inside video are plain pixel data
              period      <= P_VIDEO;
              video_start <= first_data;
              first_data  <= 1'b0;
            end
          end
          default: begin
            state  <= S_BLANK;
            period <= P_BLANK;
          end
        endcase
      end
    end
  end

`ifdef PIXEL_COUNT_EN
  logic [CNT_W-1:0] pix_cnt;
  logic             pix_inc;
  logic             pix_latch;

  assign pix_inc   = in_valid && (state == S_VIDEO) && !is_ctl;
  assign pix_latch = in_valid && (state == S_VIDEO) && is_ctl;

  // saturating pixel count, captured into line_len when video ends
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt  <= '0;
      line_len <= '0;
    end else if (pix_latch) begin
      line_len <= pix_cnt;
      pix_cnt  <= '0;
    end else if (pix_inc && (pix_cnt != {CNT_W{1'b1}})) begin
      pix_cnt <= pix_cnt + 1'b1;
    end
  end
`else
  assign line_len = '0;
`endif

endmodule

// File: tb/tb_tmds_period_decoder.sv
// Scoreboard bench for tmds_period_decoder: directed sequences plus random
// symbol streams checked against a symbol-level reference model.
module tb_tmds_period_decoder;
  import tmds_pkg::*;

  localparam int PL = 8;
  localparam int CW = 12;
  localparam logic [9:0] G = GUARD_CH0;
  localparam int SAT = (1 << CW) - 1;
`ifdef PIXEL_COUNT_EN
  localparam bit PIX_EN = 1'b1;
`else
  localparam bit PIX_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [9:0]    in_sym = 10'd0;
  logic          out_valid;
  logic [9:0]    out_sym;
  logic [1:0]    period;
  logic [1:0]    ctl;
  logic          video_start;
  logic          video_end;
  logic          err;
  logic [CW-1:0] line_len;

  tmds_period_decoder #(.GUARD_SYM(G), .PREAMBLE_LEN(PL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sym(in_sym),
    .out_valid(out_valid), .out_sym(out_sym), .period(period), .ctl(ctl),
    .video_start(video_start), .video_end(video_end), .err(err),
    .line_len(line_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]    sym;
    logic [1:0]    period;
    logic [1:0]    ctl;
    logic          vs;
    logic          ve;
    logic          err;
    logic [CW-1:0] ll;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_ov = 1'b0;

  logic [9:0] codes [4] = '{CTL_00, CTL_01, CTL_10, CTL_11};

  // model state: phase 0 blanking, 1 after first guard, 2 in video
  int m_ctl, m_run, m_phase, m_first, m_pix, m_line;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_ctl = 0; m_run = 0; m_phase = 0; m_first = 0; m_pix = 0; m_line = 0;
  endtask

  task automatic model_step(input logic [9:0] s, output exp_t e);
    bit isc = 1'b0;
    int c = 0;
    for (int k = 0; k < 4; k++) if (s == codes[k]) begin isc = 1'b1; c = k; end
    e.sym = s; e.vs = 1'b0; e.ve = 1'b0; e.err = 1'b0; e.period = 2'd0;
    if (isc) begin
      if (m_phase == 0) begin
        m_run = (c == m_ctl) ? ((m_run + 1 > PL) ? PL : m_run + 1) : 1;
      end else begin
        if (m_phase == 1) e.err = 1'b1;
        if (m_phase == 2) begin e.ve = 1'b1; m_line = m_pix; m_pix = 0; end
        m_run = 1;
      end
      m_phase = 0; m_first = 0; m_ctl = c;
    end else if (m_phase == 0) begin
      if (s == G && m_run >= PL) begin m_phase = 1; e.period = 2'd1; end
      else begin e.err = 1'b1; m_run = 0; end
    end else if (m_phase == 1) begin
      if (s == G) begin m_phase = 2; m_first = 1; e.period = 2'd1; end
      else begin e.err = 1'b1; m_phase = 0; m_run = 0; end
    end else begin
      e.period = 2'd2; e.vs = m_first[0]; m_first = 0;
      if (m_pix < SAT) m_pix++;
    end
    e.ctl = 2'(m_ctl);
    e.ll  = PIX_EN ? CW'(m_line) : '0;
  endtask

  task automatic send(input logic v, input logic [9:0] s);
    exp_t e;
    @(posedge clk); #1;
    in_valid = v;
    in_sym   = s;
    if (v) begin
      model_step(s, e);
      q.push_back(e);
    end
  endtask

  function automatic logic [9:0] data_sym(input int i);
    logic [9:0] base;
    base = 10'h0F0;
    return base + 10'(i % 8);
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_queue_empty", q.size(), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sym", out_sym, 0);
    check("rst_period", period, 0);
    check("rst_ctl", ctl, 0);
    check("rst_pulses", {video_start, video_end, err}, 0);
    check("rst_line_len", line_len, 0);
  endtask

  task automatic video_frame(input int n_pre, input int n_data, input logic [9:0] end_ctl, input bit gaps);
    for (int i = 0; i < n_pre; i++) begin send(1'b1, CTL_00); if (gaps) send(1'b0, 10'h3FF); end
    for (int i = 0; i < 2; i++) begin send(1'b1, G); if (gaps) send(1'b0, 10'h3FF); end
    for (int i = 0; i < n_data; i++) begin send(1'b1, data_sym(i)); if (gaps) send(1'b0, 10'h000); end
    send(1'b1, end_ctl);
  endtask

  always @(posedge clk) exp_ov <= reset ? 1'b0 : in_valid;

  // monitor: pop expected entry whenever the DUT presents a symbol
  always @(negedge clk) begin
    exp_t e;
    check("out_valid", out_valid, exp_ov);
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_sym", out_sym, e.sym);
        check("period", period, e.period);
        check("ctl", ctl, e.ctl);
        check("video_start", video_start, e.vs);
        check("video_end", video_end, e.ve);
        check("err", err, e.err);
        check("line_len", line_len, e.ll);
        check("vs_ve_exclusive", video_start & video_end, 0);
      end
    end else if (!reset) begin
      check("idle_pulses", {video_start, video_end, err}, 0);
    end
  end

  initial begin
    model_reset();
    apply_reset();

    // basic frame: 8 preamble, 2 guard, 5 data, ctl 01
    video_frame(8, 5, CTL_01, 1'b0);
    repeat (2) send(1'b0, 10'd0);
    check("frame_ctl", ctl, 2'b01);
    check("frame_line_len", line_len, PIX_EN ? 5 : 0);

    // short preamble then guard -> err
    for (int i = 0; i < 7; i++) send(1'b1, CTL_10);
    send(1'b1, G);
    // single guard then data -> err
    for (int i = 0; i < 9; i++) send(1'b1, CTL_11);
    send(1'b1, G);
    send(1'b1, 10'h0F3);
    // empty video period
    video_frame(8, 0, CTL_00, 1'b0);
    // same frame with gaps between every symbol
    video_frame(8, 5, CTL_01, 1'b1);

    // reset in the middle of video, then guard must be rejected
    for (int i = 0; i < 8; i++) send(1'b1, CTL_00);
    send(1'b1, G); send(1'b1, G);
    for (int i = 0; i < 3; i++) send(1'b1, data_sym(i));
    send(1'b0, 10'd0);
    apply_reset();
    send(1'b1, G);
    send(1'b1, G);

    // random segments
    for (int seg = 0; seg < 60; seg++) begin
      int npre, ng, nd, code;
      npre = $urandom_range(3, 11);
      ng   = ($urandom_range(0, 9) < 8) ? 2 : $urandom_range(0, 3);
      nd   = $urandom_range(0, 14);
      code = $urandom_range(0, 3);
      for (int i = 0; i < npre; i++) begin
        if ($urandom_range(0, 19) == 0) code = $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) send(1'b0, 10'($urandom));
        send(1'b1, codes[code]);
      end
      for (int i = 0; i < ng; i++) send(1'b1, G);
      for (int i = 0; i < nd; i++) begin
        if ($urandom_range(0, 3) == 0) send(1'b0, 10'($urandom));
        send(1'b1, ($urandom_range(0, 15) == 0) ? G : 10'($urandom));
      end
      send(1'b1, codes[$urandom_range(0, 3)]);
      if (seg % 20 == 19) begin
        send(1'b0, 10'd0);
        apply_reset();
      end
    end

    // long line saturates the pixel counter
    video_frame(8, 4100, CTL_10, 1'b0);
    repeat (3) send(1'b0, 10'd0);
    check("sat_line_len", line_len, PIX_EN ? SAT : 0);
    check("drain_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tmds_period_decoder.md
# tmds_period_decoder

Sink-side TMDS period decoder for one 10-bit channel. It classifies each incoming symbol as blanking/control, video guard band or video data, and tracks the preamble → guard → video sequence with a state machine. Its period code uses the same encoding the output-side mux selects on, so transmit and receive paths agree. It sits between the receive deserializer/aligner and the TMDS data decoder, and gates which symbols are passed on as pixels.

## Interface
Parameters:
- GUARD_SYM, 10'b1011001100, video leading guard-band code for this channel (ch1 uses 10'b0100110011)
- PREAMBLE_LEN, 8, minimum run of identical control symbols before a guard band is accepted
- CNT_W, 12, width of the pixel counter and line_len

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_sym is valid this cycle
- in_sym  in  10  received TMDS symbol, aligned
- out_valid  out  1  registered copy of in_valid
- out_sym  out  10  in_sym delayed one cycle
- period  out  2  classification of out_sym: 00 blank, 01 guard, 10 video (11 never driven)
- ctl  out  2  last decoded control code, held between control symbols
- video_start  out  1  one-cycle pulse with the first video symbol of a period
- video_end  out  1  one-cycle pulse with the first control symbol after video
- err  out  1  one-cycle pulse on a protocol violation
- line_len  out  CNT_W  video symbols in the last completed video period

## Operation
- Control codes: 1101010100→00, 0010101011→01, 0101010100→10, 1010101011→11.
- run_cnt tracks consecutive identical control symbols:
  - increments when the code matches the previous one; otherwise loads 1
  - saturates at PREAMBLE_LEN
- States: S_BLANK, S_GUARD, S_VIDEO. Reset enters S_BLANK with run_cnt=0.
- S_BLANK:
  - control symbol: update run_cnt and ctl, period=00
  - GUARD_SYM with run_cnt≥PREAMBLE_LEN: go to S_GUARD, period=01
  - GUARD_SYM with run_cnt<PREAMBLE_LEN: err, run_cnt=0, period=00
  - any other symbol: err, run_cnt=0, period=00
- S_GUARD:
  - GUARD_SYM: go to S_VIDEO, period=01
  - control symbol: err, go to S_BLANK, run_cnt=1, ctl updated, period=00
  - any other symbol: err, go to S_BLANK, run_cnt=0, period=00
- S_VIDEO:
  - control symbol: go to S_BLANK, run_cnt=1, ctl updated, video_end, period=00
  - any other symbol, including GUARD_SYM: video data, period=10
  - video_start fires on the first period=10 symbol after S_GUARD
- in_valid=0: no state or counter change; out_valid=0; all pulses 0; out_sym/period hold.

## Timing
- Latency is 1 cycle: the symbol at edge N appears with its classification after edge N+1.
- Reset: out_valid=0, out_sym=0, period=00, ctl=00, video_start=0, video_end=0, err=0, line_len=0.
- Reset asserted mid-period: next cycle is S_BLANK and all outputs are at reset values; no video_end is emitted.
- video_start and video_end are never high in the same cycle.
- A video period needs at least one data symbol. A control symbol directly after the second guard symbol gives video_end with no video_start and line_len=0.

## Configuration
- PIXEL_COUNT_EN defined:
  - pix_cnt (CNT_W bits) increments on each period=10 symbol and saturates at 2^CNT_W−1
  - on video_end, line_len←pix_cnt and pix_cnt←0
  - reset clears both
- PIXEL_COUNT_EN undefined: no counter logic; line_len is tied to 0.

## Structure
- tmds_pkg holds:
  - period_t enum (P_BLANK=2'b00, P_GUARD=2'b01, P_VIDEO=2'b10), shared with the transmit mux select
  - the four control-code constants
  - per-channel guard-code constants
- Sub-module tmds_sym_classify: combinational; in_sym → is_ctl, ctl_code[1:0], is_guard. It is instantiated once; the FSM and counters stay in the top module.

## Test plan
- 8× 1101010100, 2× GUARD_SYM, 5 data symbols, 1× 0010101011 → period 00×8, 01×2, 10×5, 00; video_start with the first data symbol; video_end with the control symbol; ctl=01; line_len=5 (PIXEL_COUNT_EN).
- 7× control, then GUARD_SYM → err pulse on the guard, period=00, no video_start.
- Preamble, 1× GUARD_SYM, then a data symbol → err, period=00, state back to S_BLANK.
- Valid stream with in_valid low every other cycle → same classification as a continuous stream; out_valid mirrors in_valid with 1-cycle delay; no spurious pulses.
- Reset asserted after 3 video symbols → next cycle all outputs at reset values; a fresh preamble is then required before video.
- 4100 video symbols with CNT_W=12 → line_len=4095 (saturated); without PIXEL_COUNT_EN, line_len=0.
